// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse sequencer and related blocks.
package morse_pkg;

  localparam logic [5:0] MAX_CODE     = 6'd35;
  localparam logic [5:0] INVALID_CODE = 6'd63;

  // Element durations in Morse time units
  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int GAP_UNITS      = 1;
  localparam int CHAR_GAP_UNITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_CHAR_GAP
  } state_t;

endpackage

// File: rtl/morse_sequencer_if.sv
// Symbol request / key output bundle between the symbol source and the sequencer.
interface morse_sequencer_if;
  logic       start;
  logic       abort;
  logic [5:0] symbol_code;
  logic       ready;
  logic       key_out;
  logic       busy;
  logic [2:0] element_index;
  logic [5:0] current_code;
  logic       done;
  logic       code_error;

  modport slave (
    input  start, abort, symbol_code,
    output ready, key_out, busy, element_index, current_code, done, code_error
  );

  modport master (
    output start, abort, symbol_code,
    input  ready, key_out, busy, element_index, current_code, done, code_error
  );
endinterface

// File: rtl/morse_pattern_rom.sv
// Code (0-9, A-Z) to Morse length and left-aligned pattern (bit 4 = first element, 1 = dash).
module morse_pattern_rom (
  input  logic [5:0] code_i,
  output logic [2:0] length_o,
  output logic [4:0] pattern_o
);

  logic [7:0] entry;

  // ITU table; out-of-range codes yield an empty pattern
  always_comb begin
    entry = 8'h00;
    case (code_i)
      6'd0:  entry = {3'd5, 5'b11111};
      6'd1:  entry = {3'd5, 5'b01111};
      6'd2:  entry = {3'd5, 5'b00111};
      6'd3:  entry = {3'd5, 5'b00011};
      6'd4:  entry = {3'd5, 5'b00001};
      6'd5:  entry = {3'd5, 5'b00000};
      6'd6:  entry = {3'd5, 5'b10000};
      6'd7:  entry = {3'd5, 5'b11000};
      6'd8:  entry = {3'd5, 5'b11100};
      6'd9:  entry = {3'd5, 5'b11110};
      6'd10: entry = {3'd2, 5'b01000}; // A .-
      6'd11: entry = {3'd4, 5'b10000}; // B -...
      6'd12: entry = {3'd4, 5'b10100}; // C -.-.
      6'd13: entry = {3'd3, 5'b10000}; // D -..
      6'd14: entry = {3'd1, 5'b00000}; // E .
      6'd15: entry = {3'd4, 5'b00100}; // F ..-.
      6'd16: entry = {3'd3, 5'b11000}; // G --.
      6'd17: entry = {3'd4, 5'b00000}; // H ....
      6'd18: entry = {3'd2, 5'b00000}; // I ..
      6'd19: entry = {3'd4, 5'b01110}; // J .---
      6'd20: entry = {3'd3, 5'b10100}; // K -.-
      6'd21: entry = {3'd4, 5'b01000}; // L .-..
      6'd22: entry = {3'd2, 5'b11000}; // M --
      6'd23: entry = {3'd2, 5'b10000}; // N -.
      6'd24: entry = {3'd3, 5'b11100}; // O ---
      6'd25: entry = {3'd4, 5'b01100}; // P .--.
      6'd26: entry = {3'd4, 5'b11010}; // Q --.-
      6'd27: entry = {3'd3, 5'b01000}; // R .-.
      6'd28: entry = {3'd3, 5'b00000}; // S ...
      6'd29: entry = {3'd1, 5'b10000}; // T -
      6'd30: entry = {3'd3, 5'b00100}; // U ..-
      6'd31: entry = {3'd4, 5'b00010}; // V ...-
      6'd32: entry = {3'd3, 5'b01100}; // W .--
      6'd33: entry = {3'd4, 5'b10010}; // X -..-
      6'd34: entry = {3'd4, 5'b10110}; // Y -.--
      6'd35: entry = {3'd4, 5'b11000}; // Z --..
      default: entry = 8'h00;
    endcase
  end

  assign length_o  = entry[7:5];
  assign pattern_o = entry[4:0];

endmodule

// File: rtl/morse_sequencer.sv
// Keys one symbol as a timed Morse mark/space sequence with a trailing character gap.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25000000,
  parameter int CNT_W       = 32
) (
  input  logic          clock,
  input  logic          reset,
  morse_sequencer_if.slave bus
);

  // Terminal counts per phase; the counter restarts at zero on every state entry
  localparam logic [CNT_W-1:0] DOT_LAST   = CNT_W'(DOT_UNITS      * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST  = CNT_W'(DASH_UNITS     * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_UNITS      * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CGAP_LAST  = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       len_q;
  logic [4:0]       pat_q;      // shifted left per element; bit 4 is the current element
  logic [2:0]       idx_q;
  logic [5:0]       code_q;
  logic             key_q, ready_q, busy_q, done_q, cerr_q;

  logic [2:0] rom_len;
  logic [4:0] rom_pat;

  morse_pattern_rom u_rom (
    .code_i    (bus.symbol_code),
    .length_o  (rom_len),
    .pattern_o (rom_pat)
  );

  // Sequencer FSM with unit counter; all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      code_q  <= INVALID_CODE;
      key_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cerr_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        // abort in idle suppresses a simultaneous start
        if (bus.start && !bus.abort) begin
          if (bus.symbol_code > MAX_CODE) begin
            cerr_q <= 1'b1;
          end else begin
            code_q  <= bus.symbol_code;
            len_q   <= rom_len;
            pat_q   <= rom_pat;
            idx_q   <= '0;
            cnt_q   <= '0;
            key_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_MARK;
          end
        end
      end else if (bus.abort) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        key_q   <= 1'b0;
        ready_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_MARK: begin
            if (cnt_q == (pat_q[4] ? DASH_LAST : DOT_LAST)) begin
              cnt_q   <= '0;
              key_q   <= 1'b0;
              state_q <= (idx_q + 3'd1 < len_q) ? ST_SPACE : ST_CHAR_GAP;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_SPACE: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              idx_q   <= idx_q + 3'd1;
              pat_q   <= {pat_q[3:0], 1'b0};
              key_q   <= 1'b1;
              state_q <= ST_MARK;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_CHAR_GAP: begin
            if (cnt_q == CGAP_LAST) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ready         = ready_q;
  assign bus.busy          = busy_q;
  assign bus.key_out       = key_q;
  assign bus.element_index = idx_q;
  assign bus.current_code  = code_q;
  assign bus.done          = done_q;
  assign bus.code_error    = cerr_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with UNIT_CYCLES=4.
module tb_morse_sequencer;

  localparam int U = 4;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  morse_sequencer_if bus_if ();

  morse_sequencer #(.UNIT_CYCLES(U), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {key_out, done, ready, busy, element_index}
  function automatic logic [6:0] snap();
    return {bus_if.key_out, bus_if.done, bus_if.ready, bus_if.busy, bus_if.element_index};
  endfunction

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Start a symbol at the current negedge and check every cycle up to and including done.
  // dashes is left-aligned, 1 = dash.
  task automatic run_sym(input string tag, input logic [5:0] code, input int n,
                         input logic [4:0] dashes, input int done_cyc);
    logic       ek [0:127];
    logic [2:0] ei [0:127];
    int c;
    for (int i = 0; i < 128; i++) begin ek[i] = 1'b0; ei[i] = 3'd0; end
    c = 1;
    for (int e = 0; e < n; e++) begin
      for (int k = 0; k < (dashes[4-e] ? 3*U : U); k++) begin ek[c] = 1'b1; ei[c] = 3'(e); c++; end
      for (int k = 0; k < ((e == n-1) ? 3*U : U); k++) begin ek[c] = 1'b0; ei[c] = 3'(e); c++; end
    end
    bus_if.symbol_code = code;
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    chk({tag, "_code"}, 32'(bus_if.current_code), 32'(code));
    for (int cy = 1; cy <= done_cyc; cy++) begin
      if (cy == done_cyc)
        chk($sformatf("%s_done_c%0d", tag, cy), 32'(snap()), 32'(7'b0_1_1_0_000));
      else
        chk($sformatf("%s_c%0d", tag, cy), 32'(snap()), 32'({ek[cy], 1'b0, 1'b0, 1'b1, ei[cy]}));
      if (cy != done_cyc) cyc();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.symbol_code = 6'd0;
    cyc(); cyc();
    chk("rst_outs", 32'(snap()), 32'(7'b0_0_1_0_000));
    chk("rst_code", 32'(bus_if.current_code), 32'd63);
    chk("rst_cerr", 32'(bus_if.code_error), 32'd0);
    reset = 1'b0;
    cyc();
    chk("idle_outs", 32'(snap()), 32'(7'b0_0_1_0_000));

    // A: dot-dash, done at 33
    run_sym("A", 6'd10, 2, 5'b01000, 33);
    cyc();
    chk("A_after", 32'(snap()), 32'(7'b0_0_1_0_000));

    // E: single dot, done at 17; code held afterwards
    run_sym("E", 6'd14, 1, 5'b00000, 17);
    // back-to-back: start 0 in the done cycle
    run_sym("D0", 6'd0, 5, 5'b11111, 89);
    cyc();
    chk("D0_code_held", 32'(bus_if.current_code), 32'd0);

    // invalid code: error pulse, stays idle, code unchanged
    bus_if.symbol_code = 6'd40;
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    chk("bad_cerr", 32'(bus_if.code_error), 32'd1);
    chk("bad_outs", 32'(snap()), 32'(7'b0_0_1_0_000));
    chk("bad_code", 32'(bus_if.current_code), 32'd0);
    cyc();
    chk("bad_cerr_pulse", 32'(bus_if.code_error), 32'd0);
    chk("bad_outs2", 32'(snap()), 32'(7'b0_0_1_0_000));
    run_sym("T", 6'd29, 1, 5'b10000, 25);

    // abort in idle beats start
    bus_if.symbol_code = 6'd14;
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    chk("idle_abort", 32'(snap()), 32'(7'b0_0_1_0_000));
    chk("idle_abort_code", 32'(bus_if.current_code), 32'd29);

    // Z with ignored start at cycle 3 and abort at cycle 10
    bus_if.symbol_code = 6'd35;
    bus_if.start = 1'b1;
    cyc();                       // cycle 1
    bus_if.start = 1'b0;
    chk("Z_c1", 32'(snap()), 32'(7'b1_0_0_1_000));
    cyc(); cyc();                // cycle 3
    bus_if.symbol_code = 6'd5;
    bus_if.start = 1'b1;
    cyc();                       // cycle 4
    bus_if.start = 1'b0;
    chk("Z_ign_code", 32'(bus_if.current_code), 32'd35);
    chk("Z_c4", 32'(snap()), 32'(7'b1_0_0_1_000));
    for (int i = 5; i <= 10; i++) cyc();
    chk("Z_c10", 32'(snap()), 32'(7'b1_0_0_1_000));
    bus_if.abort = 1'b1;
    cyc();                       // cycle 11
    bus_if.abort = 1'b0;
    chk("Z_abort", 32'(snap()), 32'(7'b0_0_1_0_000));
    chk("Z_abort_code", 32'(bus_if.current_code), 32'd35);
    begin
      int dn = 0;
      for (int i = 0; i < 60; i++) begin cyc(); if (bus_if.done) dn++; end
      chk("Z_no_done", 32'(dn), 32'd0);
    end

    // async reset mid-mark of O
    bus_if.symbol_code = 6'd24;
    bus_if.start = 1'b1;
    cyc();
    bus_if.start = 1'b0;
    for (int i = 2; i <= 5; i++) cyc();
    chk("O_mark", 32'(snap()), 32'(7'b1_0_0_1_000));
    #1 reset = 1'b1;
    #1;
    chk("O_rst_outs", 32'(snap()), 32'(7'b0_0_1_0_000));
    chk("O_rst_code", 32'(bus_if.current_code), 32'd63);
    @(negedge clock);
    cyc();
    reset = 1'b0;
    cyc();
    chk("O_rst_nodone", 32'(snap()), 32'(7'b0_0_1_0_000));
    run_sym("E2", 6'd14, 1, 5'b00000, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
